// File: rtl/mem_stage_dcache.sv
// MEM stage with a direct-mapped, write-through, no-write-allocate data cache and word-serial refill.
// Define DCACHE_PERF_EN to add the hitCountM/missCountM performance counters.
module mem_stage_dcache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] aluResultM,
    input  logic [31:0]       writeDataM,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [2:0]        addressingModeM,
    output logic [31:0]       readDataM,
    output logic              cacheStallM,
    output logic              misalignedM,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]       hitCountM,
    output logic [31:0]       missCountM
`endif
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int OFF_WB = (OFF_W > 0) ? OFF_W : 1;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t              state_q;
    logic [OFF_WB-1:0]   cnt_q;
    logic [NUM_LINES-1:0] valid_q;
    logic                memRead_q;
    logic                memWrite_q;
`ifdef DCACHE_PERF_EN
    logic [31:0]         hitCnt_q;
    logic [31:0]         missCnt_q;
`endif

    logic [TAG_W-1:0] tagMem  [NUM_LINES];
    logic [31:0]      dataMem [NUM_LINES][LINE_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [OFF_WB-1:0] wordOff;
    logic [31:0]       hitWord;
    logic              hit;

    assign idx     = aluResultM[OFF_W+2 +: IDX_W];
    assign tag     = aluResultM[ADDR_W-1 -: TAG_W];
    assign wordOff = (OFF_W == 0) ? '0 : aluResultM[2 +: OFF_WB];
    assign hitWord = dataMem[idx][wordOff];
    assign hit     = valid_q[idx] && (tagMem[idx] == tag);

    logic isStore;
    logic isLoad;
    logic access;
    logic sizeByte;
    logic sizeHalf;
    logic misAligned;
    logic accessOk;

    assign isStore = memWriteM;
    assign isLoad  = memReadM && !memWriteM;
    assign access  = memReadM || memWriteM;

    // Stores only know B/H/W; anything a load cannot decode is handled as a word.
    always_comb begin
        sizeByte = 1'b0;
        sizeHalf = 1'b0;
        if (isStore) begin
            sizeByte = (addressingModeM == 3'b000);
            sizeHalf = (addressingModeM == 3'b001);
        end else begin
            case (addressingModeM)
                3'b000, 3'b100: sizeByte = 1'b1;
                3'b001, 3'b101: sizeHalf = 1'b1;
                default: ;
            endcase
        end
    end

    assign misAligned = access && (sizeHalf ? aluResultM[0]
                                            : (!sizeByte && (aluResultM[1:0] != 2'b00)));
    assign accessOk   = access && !misAligned;

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    always_comb begin
        case (aluResultM[1:0])
            2'b00:   byteSel = hitWord[7:0];
            2'b01:   byteSel = hitWord[15:8];
            2'b10:   byteSel = hitWord[23:16];
            default: byteSel = hitWord[31:24];
        endcase
        halfSel = aluResultM[1] ? hitWord[31:16] : hitWord[15:0];
        case (addressingModeM)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b100:  loadData = {24'd0, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b101:  loadData = {16'd0, halfSel};
            3'b010:  loadData = hitWord;
            default: loadData = 32'd0;
        endcase
    end

    logic [3:0]  storeBe;
    logic [31:0] storeData;
    logic [31:0] mergedWord;

    // Store data is replicated into every lane so the byte enables alone pick the target bytes.
    always_comb begin
        if (sizeByte) begin
            storeBe   = 4'b0001 << aluResultM[1:0];
            storeData = {4{writeDataM[7:0]}};
        end else if (sizeHalf) begin
            storeBe   = aluResultM[1] ? 4'b1100 : 4'b0011;
            storeData = {2{writeDataM[15:0]}};
        end else begin
            storeBe   = 4'b1111;
            storeData = writeDataM;
        end
        mergedWord = hitWord;
        for (int b = 0; b < 4; b++) begin
            if (storeBe[b]) begin
                mergedWord[8*b +: 8] = storeData[8*b +: 8];
            end
        end
    end

    logic refillLast;
    assign refillLast = (state_q == REFILL) && mem_ready
                        && (cnt_q == OFF_WB'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
`ifdef DCACHE_PERF_EN
            hitCnt_q   <= 32'd0;
            missCnt_q  <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accessOk) begin
                        if (isStore) begin
                            state_q    <= WRITE;
                            memWrite_q <= 1'b1;
                        end else if (!hit) begin
                            state_q      <= REFILL;
                            cnt_q        <= '0;
                            memRead_q    <= 1'b1;
                            valid_q[idx] <= 1'b0;
`ifdef DCACHE_PERF_EN
                            missCnt_q    <= missCnt_q + 32'd1;
`endif
                        end else begin
`ifdef DCACHE_PERF_EN
                            hitCnt_q     <= hitCnt_q + 32'd1;
`endif
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (refillLast) begin
                            valid_q[idx] <= 1'b1;
                            memRead_q    <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        memWrite_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Array contents need no reset: valid bits alone decide whether a line can hit.
    always_ff @(posedge clk) begin
        if ((state_q == REFILL) && mem_ready) begin
            dataMem[idx][cnt_q] <= mem_rdata;
        end
        if (refillLast) begin
            tagMem[idx] <= tag;
        end
        if ((state_q == WRITE) && mem_ready && hit) begin
            dataMem[idx][wordOff] <= mergedWord;
        end
    end

    assign mem_read  = memRead_q;
    assign mem_write = memWrite_q;
    assign mem_be    = memWrite_q ? storeBe : 4'b0000;
    assign mem_wdata = memWrite_q ? storeData : 32'd0;

    always_comb begin
        case (state_q)
            REFILL:  mem_addr = (aluResultM & ~LINE_MASK) | (ADDR_W'(cnt_q) << 2);
            WRITE:   mem_addr = aluResultM & ~ADDR_W'(3);
            default: mem_addr = '0;
        endcase
    end

    // Status outputs are forced low while reset is held, not just after the next edge.
    always_comb begin
        case (state_q)
            IDLE:          cacheStallM = rst && accessOk && (isStore || !hit);
            REFILL, WRITE: cacheStallM = rst;
            default:       cacheStallM = 1'b0;
        endcase
    end

    assign readDataM   = (rst && (state_q == IDLE) && isLoad && !misAligned && hit)
                         ? loadData : 32'd0;
    assign misalignedM = rst && (state_q == IDLE) && misAligned;

`ifdef DCACHE_PERF_EN
    assign hitCountM  = hitCnt_q;
    assign missCountM = missCnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Scoreboard bench for mem_stage_dcache: a flat-memory reference model predicts load data,
// alignment faults and the backing-memory traffic each access should produce.
module tb_mem_stage_dcache;

    localparam int NUM_LINES  = 64;
    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] aluResultM;
    logic [31:0]       writeDataM;
    logic              memReadM;
    logic              memWriteM;
    logic [2:0]        addressingModeM;
    logic [31:0]       readDataM;
    logic              cacheStallM;
    logic              misalignedM;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
`ifdef DCACHE_PERF_EN
    logic [31:0]       hitCountM;
    logic [31:0]       missCountM;
`endif

    mem_stage_dcache #(
        .NUM_LINES(NUM_LINES),
        .LINE_WORDS(LINE_WORDS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .aluResultM(aluResultM),
        .writeDataM(writeDataM),
        .memReadM(memReadM),
        .memWriteM(memWriteM),
        .addressingModeM(addressingModeM),
        .readDataM(readDataM),
        .cacheStallM(cacheStallM),
        .misalignedM(misalignedM),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be(mem_be),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef DCACHE_PERF_EN
        ,
        .hitCountM(hitCountM),
        .missCountM(missCountM)
`endif
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    exp_t        expQ[$];
    req_t        reqQ[$];
    logic [31:0] mem[int unsigned];
    logic [31:0] refMem[int unsigned];
    bit          refValid[NUM_LINES];
    int unsigned refTag[NUM_LINES];

    int checks = 0;
    int errors = 0;
    int readsServed = 0;
    bit randLat = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] initWord(int unsigned w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] memWord(int unsigned w);
        return mem.exists(w) ? mem[w] : initWord(w);
    endfunction

    function automatic logic [31:0] refWord(int unsigned w);
        return refMem.exists(w) ? refMem[w] : initWord(w);
    endfunction

    function automatic logic [31:0] extractRef(logic [31:0] w, logic [2:0] mode, logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (mode)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit misRef(bit st, logic [2:0] mode, logic [1:0] a);
        if (st) begin
            case (mode)
                3'b000:  return 1'b0;
                3'b001:  return a[0];
                default: return a != 2'b00;
            endcase
        end
        case (mode)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            default:        return a != 2'b00;
        endcase
    endfunction

    task automatic finishRun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Predict the access with the flat-memory model, then drive it and hold until the stall clears.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] mode,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input bit useExp, input logic [31:0] expRd, output int stalls);
        exp_t        e;
        req_t        r;
        bit          mis;
        int unsigned w;
        int unsigned li;
        int unsigned tg;
        logic [31:0] v;
        stalls = 0;
        if (rd || wr) begin
            mis = misRef(wr, mode, addr[1:0]);
            w   = addr >> 2;
            li  = (addr / LINE_BYTES) % NUM_LINES;
            tg  = addr / (LINE_BYTES * NUM_LINES);
            e.rd  = 32'd0;
            e.mis = mis;
            if (!mis && wr) begin
                r.isWrite = 1'b1;
                r.addr    = addr & ~32'd3;
                v         = refWord(w);
                case (mode)
                    3'b000: begin
                        r.be    = 4'b0001 << addr[1:0];
                        r.wdata = {4{wd[7:0]}};
                        v[8*addr[1:0] +: 8] = wd[7:0];
                    end
                    3'b001: begin
                        r.be    = addr[1] ? 4'b1100 : 4'b0011;
                        r.wdata = {2{wd[15:0]}};
                        v[16*addr[1] +: 16] = wd[15:0];
                    end
                    default: begin
                        r.be    = 4'b1111;
                        r.wdata = wd;
                        v       = wd;
                    end
                endcase
                reqQ.push_back(r);
                refMem[w] = v;
            end else if (!mis) begin
                if (!(refValid[li] && refTag[li] == tg)) begin
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        r.isWrite = 1'b0;
                        r.addr    = (addr & ~32'(LINE_BYTES - 1)) + 32'(4 * k);
                        r.be      = 4'b0000;
                        r.wdata   = 32'd0;
                        reqQ.push_back(r);
                    end
                    refValid[li] = 1'b1;
                    refTag[li]   = tg;
                end
                e.rd = useExp ? expRd : extractRef(refWord(w), mode, addr[1:0]);
            end
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        memReadM        = rd;
        memWriteM       = wr;
        addressingModeM = mode;
        aluResultM      = addr;
        writeDataM      = wd;
        forever begin
            @(negedge clk);
            if (!(rd || wr) || !cacheStallM) break;
            stalls++;
            if (stalls > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL stallTimeout: got %0d stall cycles expected at most 300", stalls);
                finishRun();
            end
        end
    endtask

    // Completion monitor: every access retires on the one cycle it is present with no stall.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (memReadM || memWriteM) && !cacheStallM) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRetire", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("readDataM", readDataM, e.rd);
                checkOutput("misalignedM", {31'd0, misalignedM}, {31'd0, e.mis});
            end
        end
    end

    // Backing memory: answers each request after a fixed or random number of cycles.
    initial begin
        int   waitCnt;
        int   curLat;
        req_t r;
        waitCnt   = 0;
        curLat    = 2;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!rst || !(mem_read || mem_write)) begin
                waitCnt = 0;
            end else begin
                if (waitCnt == 0) curLat = randLat ? int'($urandom_range(1, 3)) : 2;
                waitCnt++;
                if (waitCnt >= curLat) begin
                    waitCnt = 0;
                    if (reqQ.size() == 0) begin
                        checkOutput("unexpectedRequest", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        r = reqQ.pop_front();
                        checkOutput("reqIsWrite", {31'd0, mem_write}, {31'd0, r.isWrite});
                        checkOutput("reqIsRead", {31'd0, mem_read}, {31'd0, !r.isWrite});
                        checkOutput("mem_addr", mem_addr, r.addr);
                    end
                    if (mem_write) begin
                        checkOutput("mem_be", {28'd0, mem_be}, {28'd0, r.be});
                        checkOutput("mem_wdata", mem_wdata, r.wdata);
                        for (int b = 0; b < 4; b++) begin
                            logic [31:0] cur;
                            cur = memWord(mem_addr >> 2);
                            if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                            mem[mem_addr >> 2] = cur;
                        end
                    end else begin
                        mem_rdata = memWord(mem_addr >> 2);
                        readsServed++;
                    end
                    mem_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got no end of run expected finish before 1000000");
        finishRun();
    end

    initial begin
        int          st;
        int          base;
        int          guard;
        int          kind;
        logic [2:0]  mode;
        logic [31:0] addr;

        rst             = 1'b0;
        memReadM        = 1'b1;
        memWriteM       = 1'b0;
        addressingModeM = 3'b010;
        aluResultM      = 32'h100;
        writeDataM      = 32'd0;
        #3;
        checkOutput("rstMemRead", {31'd0, mem_read}, 32'd0);
        checkOutput("rstMemWrite", {31'd0, mem_write}, 32'd0);
        checkOutput("rstStall", {31'd0, cacheStallM}, 32'd0);
        checkOutput("rstReadData", readDataM, 32'd0);
        checkOutput("rstMisaligned", {31'd0, misalignedM}, 32'd0);
        #17;
        memReadM = 1'b0;
        #2;
        rst = 1'b1;

        $display("[TB] cold line fill and hit");
        mem[32'h100 >> 2] = 32'h11; refMem[32'h100 >> 2] = 32'h11;
        mem[32'h104 >> 2] = 32'h22; refMem[32'h104 >> 2] = 32'h22;
        mem[32'h108 >> 2] = 32'h33; refMem[32'h108 >> 2] = 32'h33;
        mem[32'h10C >> 2] = 32'h44; refMem[32'h10C >> 2] = 32'h44;
        applyStimulus(1, 0, 3'b010, 32'h100, 32'd0, 1, 32'h11, st);
        checkOutput("coldStallCycles", st, 32'(1 + 2 * LINE_WORDS));
        applyStimulus(1, 0, 3'b010, 32'h108, 32'd0, 1, 32'h33, st);
        checkOutput("hitStallCycles", st, 32'd0);

        $display("[TB] load extraction");
        mem[32'h200 >> 2] = 32'h80FF7F01; refMem[32'h200 >> 2] = 32'h80FF7F01;
        applyStimulus(1, 0, 3'b000, 32'h200, 32'd0, 1, 32'h00000001, st);
        applyStimulus(1, 0, 3'b000, 32'h201, 32'd0, 1, 32'h0000007F, st);
        applyStimulus(1, 0, 3'b000, 32'h202, 32'd0, 1, 32'hFFFFFFFF, st);
        applyStimulus(1, 0, 3'b100, 32'h202, 32'd0, 1, 32'h000000FF, st);
        applyStimulus(1, 0, 3'b001, 32'h202, 32'd0, 1, 32'hFFFF80FF, st);
        applyStimulus(1, 0, 3'b101, 32'h202, 32'd0, 1, 32'h000080FF, st);

        $display("[TB] store byte on cached line");
        applyStimulus(0, 1, 3'b000, 32'h203, 32'h000000AB, 0, 32'd0, st);
        checkOutput("storeStallCycles", st, 32'd3);
        applyStimulus(1, 0, 3'b010, 32'h200, 32'd0, 1, 32'hABFF7F01, st);
        checkOutput("storeThenHitStall", st, 32'd0);

        $display("[TB] store miss does not allocate");
        applyStimulus(0, 1, 3'b010, 32'h400, 32'hDEADBEEF, 0, 32'd0, st);
        checkOutput("storeMissStall", st, 32'd3);
        applyStimulus(1, 0, 3'b010, 32'h400, 32'd0, 1, 32'hDEADBEEF, st);
        checkOutput("loadAfterStoreMissStall", st, 32'(1 + 2 * LINE_WORDS));

        $display("[TB] misaligned accesses");
        applyStimulus(1, 0, 3'b001, 32'h301, 32'd0, 0, 32'd0, st);
        checkOutput("misHalfStall", st, 32'd0);
        applyStimulus(1, 0, 3'b010, 32'h302, 32'd0, 0, 32'd0, st);
        checkOutput("misWordStall", st, 32'd0);

        $display("[TB] reset during refill");
        base = readsServed;
        for (int k = 0; k < 2; k++) begin
            req_t r;
            r.isWrite = 1'b0;
            r.addr    = 32'h500 + 32'(4 * k);
            r.be      = 4'b0000;
            r.wdata   = 32'd0;
            reqQ.push_back(r);
        end
        @(posedge clk);
        #1;
        memReadM        = 1'b1;
        memWriteM       = 1'b0;
        addressingModeM = 3'b010;
        aluResultM      = 32'h500;
        guard = 0;
        while (readsServed < base + 2) begin
            @(posedge clk);
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL refillTimeout: got %0d reads expected %0d", readsServed - base, 2);
                finishRun();
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRefillRstRead", {31'd0, mem_read}, 32'd0);
        checkOutput("midRefillRstStall", {31'd0, cacheStallM}, 32'd0);
        memReadM = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) refValid[i] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(1, 0, 3'b010, 32'h500, 32'd0, 0, 32'd0, st);
        checkOutput("refillAfterRstStall", st, 32'(1 + 2 * LINE_WORDS));
        checkOutput("readsAfterRst", readsServed - base, 32'(2 + LINE_WORDS));

        $display("[TB] randomized traffic");
        randLat = 1'b1;
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            addr = 32'h1000 + 32'($urandom_range(0, 2)) * 32'(LINE_BYTES * NUM_LINES)
                   + 32'($urandom_range(0, 3)) * 32'(LINE_BYTES) + 32'($urandom_range(0, 15));
            if (kind <= 4) begin
                mode = 3'($urandom_range(0, 7));
                applyStimulus(1, 0, mode, addr, $urandom, 0, 32'd0, st);
            end else if (kind <= 8) begin
                mode = 3'($urandom_range(0, 2));
                applyStimulus(kind == 8, 1, mode, addr, $urandom, 0, 32'd0, st);
            end else begin
                applyStimulus(0, 0, 3'b000, addr, 32'd0, 0, 32'd0, st);
            end
        end

        @(posedge clk);
        #1;
        memReadM  = 1'b0;
        memWriteM = 1'b0;
        repeat (5) @(posedge clk);
        checkOutput("pendingRetires", expQ.size(), 32'd0);
        checkOutput("pendingRequests", reqQ.size(), 32'd0);
        finishRun();
    end

endmodule
